fp_normalize: RTL and testbench



---
 rtl/fp_norm_pkg.sv | 16 +
 rtl/fp_normalize_if.sv | 36 +++
 rtl/fp_norm_round.sv | 21 ++
 rtl/fp_normalize.sv | 143 ++++++++++++++
 tb/tb_fp_normalize.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fp_norm_pkg.sv
// Shared types and constants for the floating-point post-add normalizer.
// Default mantissa/exponent widths and the saturating exponent code live here.
package fp_norm_pkg;

    localparam int MANT_W_DEF = 16;
    localparam int EXP_W_DEF  = 8;

    localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/fp_normalize_if.sv
// Operand/result handshake bundle between the adder core, the normalizer and
// the result-packing stage. The slave modport is the normalizer's view.
interface fp_normalize_if
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_mant;
    logic [EXP_W-1:0]  in_exp;
    logic              in_sign;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_sign;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;
    logic              out_inexact;

    modport slave (
        input  in_valid, in_mant, in_exp, in_sign, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_sign,
               out_zero, out_ovf, out_unf, out_inexact
    );

    modport master (
        output in_valid, in_mant, in_exp, in_sign, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_sign,
               out_zero, out_ovf, out_unf, out_inexact
    );
endinterface

// File: rtl/fp_norm_round.sv
// Guard-bit round-to-nearest-even incrementer for the right-shift path.
// Only present when FP_NORM_ROUND_EN is defined; the truncating build omits it.
`ifdef FP_NORM_ROUND_EN
module fp_norm_round
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic [MANT_W-1:0] i_mant,
    input  logic              i_guard,
    output logic [MANT_W-1:0] o_mant,
    output logic              o_carry
);
    // With only a guard bit (no sticky), a set guard is an exact tie, so
    // round up only when that makes the result even.
    logic w_inc;

    assign w_inc = i_guard & i_mant[0];
    assign {o_carry, o_mant} = {1'b0, i_mant} + {{MANT_W{1'b0}}, w_inc};
endmodule
`endif

// File: rtl/fp_normalize.sv
// Iterative post-add normalizer: one shift decision per cycle until bit MANT_W-1
// leads. Define FP_NORM_ROUND_EN for RNE on the right-shift path (else truncate).
module fp_normalize
    import fp_norm_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_normalize_if.slave bus
);
    localparam logic [EXP_W:0] EXP_SAT = {1'b0, {EXP_W{1'b1}}};

    state_e            r_state,   w_state_nxt;
    logic [MANT_W:0]   r_mant,    w_mant_nxt;
    logic [EXP_W-1:0]  r_exp,     w_exp_nxt;
    logic              r_sign,    w_sign_nxt;
    logic              r_zero,    w_zero_nxt;
    logic              r_ovf,     w_ovf_nxt;
    logic              r_unf,     w_unf_nxt;
    logic              r_inexact, w_inexact_nxt;

    logic [MANT_W-1:0] w_shr_mant;
    logic              w_guard;
    logic [MANT_W-1:0] w_rnd_mant;
    logic              w_rnd_carry;
    logic [MANT_W-1:0] w_rnd_norm;
    logic [EXP_W:0]    w_exp_inc;

    assign w_shr_mant = r_mant[MANT_W:1];
    assign w_guard    = r_mant[0];

`ifdef FP_NORM_ROUND_EN
    fp_norm_round #(.MANT_W(MANT_W)) u_round (
        .i_mant  (w_shr_mant),
        .i_guard (w_guard),
        .o_mant  (w_rnd_mant),
        .o_carry (w_rnd_carry)
    );
`else
    assign w_rnd_mant  = w_shr_mant;
    assign w_rnd_carry = 1'b0;
`endif

    // A rounding carry re-normalizes to 1.000... and bumps the exponent a second time.
    assign w_rnd_norm = w_rnd_carry ? {1'b1, {(MANT_W-1){1'b0}}} : w_rnd_mant;
    assign w_exp_inc  = {1'b0, r_exp} + (EXP_W+1)'(1) + {{EXP_W{1'b0}}, w_rnd_carry};

    // NOTE: every next-value signal is defaulted to hold first so no path infers a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_mant_nxt    = r_mant;
        w_exp_nxt     = r_exp;
        w_sign_nxt    = r_sign;
        w_zero_nxt    = r_zero;
        w_ovf_nxt     = r_ovf;
        w_unf_nxt     = r_unf;
        w_inexact_nxt = r_inexact;

        unique case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt   = SHIFT;
                    w_mant_nxt    = bus.in_mant;
                    w_exp_nxt     = bus.in_exp;
                    w_sign_nxt    = bus.in_sign;
                    w_zero_nxt    = 1'b0;
                    w_ovf_nxt     = 1'b0;
                    w_unf_nxt     = 1'b0;
                    w_inexact_nxt = 1'b0;
                end
            end
            SHIFT: begin
                if (r_mant == '0) begin
                    w_exp_nxt   = '0;
                    w_zero_nxt  = 1'b1;
                    w_state_nxt = DONE;
                end else if (r_mant[MANT_W]) begin
                    w_inexact_nxt = w_guard;
                    w_state_nxt   = DONE;
                    // Compared one bit wider so an incoming all-ones exponent cannot wrap.
                    if (w_exp_inc >= EXP_SAT) begin
                        w_ovf_nxt  = 1'b1;
                        w_mant_nxt = '0;
                        w_exp_nxt  = '1;
                    end else begin
                        w_mant_nxt = {1'b0, w_rnd_norm};
                        w_exp_nxt  = w_exp_inc[EXP_W-1:0];
                    end
                end else if (r_mant[MANT_W-1]) begin
                    w_state_nxt = DONE;
                end else if (r_exp == '0) begin
                    w_unf_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_mant_nxt = r_mant << 1;
                    w_exp_nxt  = r_exp - EXP_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mant    <= '0;
            r_exp     <= '0;
            r_sign    <= 1'b0;
            r_zero    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inexact <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mant    <= w_mant_nxt;
            r_exp     <= w_exp_nxt;
            r_sign    <= w_sign_nxt;
            r_zero    <= w_zero_nxt;
            r_ovf     <= w_ovf_nxt;
            r_unf     <= w_unf_nxt;
            r_inexact <= w_inexact_nxt;
        end
    end

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = (r_state == DONE);
    assign bus.out_mant    = r_mant[MANT_W-1:0];
    assign bus.out_exp     = r_exp;
    assign bus.out_sign    = r_sign;
    assign bus.out_zero    = r_zero;
    assign bus.out_ovf     = r_ovf;
    assign bus.out_unf     = r_unf;
    assign bus.out_inexact = r_inexact;

endmodule

// File: tb/tb_fp_normalize.sv
// Directed-vector bench for fp_normalize with hand-computed results and latencies.
// Expectations for the right-shift cases follow FP_NORM_ROUND_EN.
module tb_fp_normalize;
    import fp_norm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_normalize_if #(.MANT_W(16), .EXP_W(8)) bus ();

    fp_normalize #(.MANT_W(16), .EXP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic start_op(input logic [16:0] m, input logic [7:0] e, input logic s);
        bus.in_mant  = m;
        bus.in_exp   = e;
        bus.in_sign  = s;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Accept edge counts as edge 1; bounded so a stuck FSM still reaches the summary.
    task automatic wait_done(input string tag, input int want_lat);
        int lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
        end
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        check({tag, ".lat"}, lat, want_lat);
    endtask

    task automatic check_out(input string tag, input logic [15:0] m, input logic [7:0] e,
                             input logic s, input logic [3:0] flags);
        check({tag, ".mant"}, {16'd0, bus.out_mant}, {16'd0, m});
        check({tag, ".exp"}, {24'd0, bus.out_exp}, {24'd0, e});
        check({tag, ".sign"}, {31'd0, bus.out_sign}, {31'd0, s});
        check({tag, ".flags"},
              {28'd0, bus.out_zero, bus.out_ovf, bus.out_unf, bus.out_inexact},
              {28'd0, flags});
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".vld_drop"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".rdy_back"}, {31'd0, bus.in_ready}, 32'd1);
    endtask

    // flags = {zero, ovf, unf, inexact}
    task automatic run(input string tag, input logic [16:0] m, input logic [7:0] e,
                       input logic s, input logic [15:0] want_m, input logic [7:0] want_e,
                       input logic [3:0] flags, input int lat);
        check({tag, ".rdy"}, {31'd0, bus.in_ready}, 32'd1);
        start_op(m, e, s);
        wait_done(tag, lat);
        check_out(tag, want_m, want_e, s, flags);
        handoff(tag);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mant   = '0;
        bus.in_exp    = '0;
        bus.in_sign   = 1'b0;
        bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        check_out("rst", 16'h0000, 8'h00, 1'b0, 4'b0000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run("norm",  17'h08000, 8'h40, 1'b0, 16'h8000, 8'h40, 4'b0000, 2);
        run("lsh15", 17'h00001, 8'h40, 1'b1, 16'h8000, 8'h31, 4'b0000, 17);
        run("lsh3",  17'h01234, 8'h10, 1'b0, 16'h91A0, 8'h0D, 4'b0000, 5);
`ifdef FP_NORM_ROUND_EN
        run("rsh",   17'h18003, 8'h40, 1'b1, 16'hC002, 8'h41, 4'b0001, 2);
        run("rshcy", 17'h1FFFF, 8'h40, 1'b0, 16'h8000, 8'h42, 4'b0001, 2);
        run("rshof", 17'h1FFFF, 8'hFD, 1'b0, 16'h0000, 8'hFF, 4'b0101, 2);
`else
        run("rsh",   17'h18003, 8'h40, 1'b1, 16'hC001, 8'h41, 4'b0001, 2);
        run("rshcy", 17'h1FFFF, 8'h40, 1'b0, 16'hFFFF, 8'h41, 4'b0001, 2);
        run("rshof", 17'h1FFFF, 8'hFD, 1'b0, 16'hFFFF, 8'hFE, 4'b0001, 2);
`endif
        run("rshev", 17'h18002, 8'h40, 1'b0, 16'hC001, 8'h41, 4'b0000, 2);
        run("ovf",   17'h10000, 8'hFE, 1'b0, 16'h0000, 8'hFF, 4'b0100, 2);
        run("zero",  17'h00000, 8'h55, 1'b1, 16'h0000, 8'h00, 4'b1000, 2);
        run("unf",   17'h00100, 8'h03, 1'b0, 16'h0800, 8'h00, 4'b0010, 5);
        run("unf0",  17'h00100, 8'h00, 1'b0, 16'h0100, 8'h00, 4'b0010, 2);

        // Result held under back-pressure while new operands are offered and ignored.
        start_op(17'h08000, 8'h20, 1'b1);
        wait_done("hold", 2);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_mant  = 17'h00001;
            bus.in_exp   = 8'h77;
            @(posedge clk);
            #1;
            check("hold.valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold.in_ready", {31'd0, bus.in_ready}, 32'd0);
            check_out("hold", 16'h8000, 8'h20, 1'b1, 4'b0000);
        end
        bus.in_valid = 1'b0;
        handoff("hold");
        run("after_hold", 17'h00300, 8'h20, 1'b0, 16'hC000, 8'h1A, 4'b0000, 8);

        // Asynchronous reset in the middle of a long shift sequence.
        start_op(17'h00001, 8'h40, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        check("mid.busy", {31'd0, bus.in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid.rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mid.rst_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid.rst_exp", {24'd0, bus.out_exp}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run("post_rst", 17'h08000, 8'h40, 1'b0, 16'h8000, 8'h40, 4'b0000, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
